// File: rtl/v810_bus_pkg.sv
// Shared types and byte-lane helper for the V810 bus target.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RDY  = 2'd3
    } state_e;

    // CPU bus status codes; only captured for debug visibility.
    typedef enum logic [1:0] {
        ST_SYS   = 2'b00,
        ST_RSVD  = 2'b01,
        ST_FETCH = 2'b10,
        ST_DATA  = 2'b11
    } st_e;

    // Active-high memory byte enables from CPU BEn; a 16-bit port only
    // serves the half-word picked by A[1].
    function automatic logic [3:0] lane_mbe(logic [3:0] ben_n, logic a1, logic bus16);
        logic [3:0] be;
        be = ~ben_n;
        if (!bus16)
            return be;
        return a1 ? {be[3:2], 2'b00} : {2'b00, be[1:0]};
    endfunction

endpackage

// File: rtl/v810_bus_target_lane.sv
// Combinational byte-lane steering between the CPU bus and the memory port.
module v810_bus_target_lane
    import v810_bus_pkg::*;
#(
    parameter bit BUS16 = 1'b0
) (
    input  logic [3:0]  ben_n,
    input  logic        a1,
    input  logic [31:0] wd,
    input  logic [31:0] mrd,
    output logic [3:0]  mbe,
    output logic [31:0] mwd,
    output logic [31:0] rd
);

    logic [15:0] half;

    // 16-bit mode: writes come in on the low half, reads are mirrored to both halves
    always_comb begin
        half = a1 ? mrd[31:16] : mrd[15:0];
        mbe  = lane_mbe(ben_n, a1, BUS16);
        mwd  = BUS16 ? {wd[15:0], wd[15:0]} : wd;
        rd   = BUS16 ? {half, half} : mrd;
    end

endmodule

// File: rtl/v810_bus_target.sv
// V810 bus responder: decodes a window and turns each bus cycle into one
// MREQ/MACK transaction, returning READYn (and SZRQn in 16-bit mode).
module v810_bus_target
    import v810_bus_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0700_0000,
    parameter logic [31:0] MASK        = 32'hFF00_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          BUS16       = 1'b0,
    parameter int          MA_W        = 22
) (
    input  logic            CLK,
    input  logic            RESn,
    input  logic            CE,
    input  logic [31:0]     A,
    input  logic [31:0]     D_I,
    input  logic [3:0]      BEn,
    input  logic [1:0]      ST,
    input  logic            DAn,
    input  logic            MRQn,
    input  logic            RW,
    input  logic            BCYSTn,
    output logic [31:0]     D_O,
    output logic            DOE,
    output logic            READYn,
    output logic            SZRQn,
    output logic            SEL,
    output logic [MA_W-1:0] MA,
    output logic [31:0]     MWD,
    output logic [3:0]      MBE,
    output logic            MWE,
    output logic            MREQ,
    input  logic            MACK,
    input  logic [31:0]     MRD,
    output logic            ERR
);

    state_e          state_q, state_d;
    logic [MA_W-1:0] ma_q, ma_d;
    logic            a1_q, a1_d;
    logic [31:0]     wd_q, wd_d;
    logic [3:0]      be_q, be_d;
    logic            rw_q, rw_d;
    st_e             st_q, st_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     dout_q, dout_d;
    logic            sel_q, sel_d, mreq_q, mreq_d, mwe_q, mwe_d;
    logic            ready_n_q, ready_n_d, szrq_n_q, szrq_n_d;
    logic            doe_q, doe_d, err_q, err_d;

    logic            hit;
    logic [31:0]     rd_lane;
    logic            st_unused;

    assign st_unused = ^st_q;

    v810_bus_target_lane #(.BUS16(BUS16)) u_lane (
        .ben_n (~be_q),
        .a1    (a1_q),
        .wd    (wd_q),
        .mrd   (MRD),
        .mbe   (MBE),
        .mwd   (MWD),
        .rd    (rd_lane)
    );

    // Next-state and registered-output logic; nothing moves on CE=0 edges
    always_comb begin
        state_d   = state_q;
        ma_d      = ma_q;
        a1_d      = a1_q;
        wd_d      = wd_q;
        be_d      = be_q;
        rw_d      = rw_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        sel_d     = sel_q;
        mreq_d    = mreq_q;
        mwe_d     = mwe_q;
        ready_n_d = ready_n_q;
        szrq_n_d  = szrq_n_q;
        doe_d     = doe_q;
        err_d     = err_q;

        hit = !BCYSTn && !MRQn && !DAn && ((A & MASK) == (BASE & MASK));

        if (CE) begin
            // Stray acknowledges and overlapping decodes are protocol errors
            if (MACK && state_q != REQ)
                err_d = 1'b1;
            if (hit && state_q != IDLE)
                err_d = 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        ma_d    = A[MA_W+1:2];
                        a1_d    = A[1];
                        wd_d    = D_I;
                        be_d    = ~BEn;
                        rw_d    = RW;
                        st_d    = st_e'(ST);
                        sel_d   = 1'b1;
                        mreq_d  = 1'b1;
                        mwe_d   = ~RW;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (MACK) begin
                        mreq_d = 1'b0;
                        if (rw_q)
                            dout_d = rd_lane;
                        if (WAIT_STATES == 0) begin
                            ready_n_d = 1'b0;
                            doe_d     = rw_q;
                            szrq_n_d  = ~BUS16;
                            state_d   = RDY;
                        end else begin
                            cnt_d   = 4'(WAIT_STATES);
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        ready_n_d = 1'b0;
                        doe_d     = rw_q;
                        szrq_n_d  = ~BUS16;
                        state_d   = RDY;
                    end
                end
                RDY: begin
                    ready_n_d = 1'b1;
                    doe_d     = 1'b0;
                    szrq_n_d  = 1'b1;
                    sel_d     = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; reset wins regardless of CE
    always_ff @(posedge CLK) begin
        if (!RESn) begin
            state_q   <= IDLE;
            ma_q      <= '0;
            a1_q      <= 1'b0;
            wd_q      <= '0;
            be_q      <= '0;
            rw_q      <= 1'b0;
            st_q      <= ST_SYS;
            cnt_q     <= '0;
            dout_q    <= '0;
            sel_q     <= 1'b0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            ready_n_q <= 1'b1;
            szrq_n_q  <= 1'b1;
            doe_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ma_q      <= ma_d;
            a1_q      <= a1_d;
            wd_q      <= wd_d;
            be_q      <= be_d;
            rw_q      <= rw_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            sel_q     <= sel_d;
            mreq_q    <= mreq_d;
            mwe_q     <= mwe_d;
            ready_n_q <= ready_n_d;
            szrq_n_q  <= szrq_n_d;
            doe_q     <= doe_d;
            err_q     <= err_d;
        end
    end

    assign D_O    = dout_q;
    assign DOE    = doe_q;
    assign READYn = ready_n_q;
    assign SZRQn  = szrq_n_q;
    assign SEL    = sel_q;
    assign MA     = ma_q;
    assign MWE    = mwe_q;
    assign MREQ   = mreq_q;
    assign ERR    = err_q;

endmodule
